// File: rtl/nyx_arb_pkg.sv
// Shared arbiter types and helpers: lock FSM encoding and the id-width rule.
package nyx_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // A single requester still needs a one-bit id so ports never collapse to zero width.
  function automatic int arb_idw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first asserted request at or after ptr, wrapping modulo N.
module rr_pick
  import nyx_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IDW = arb_idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_any
);

  localparam logic [IDW:0] N_W = (IDW+1)'(N);

  logic [IDW:0] cand;

  // Scan from the farthest offset back to ptr so the nearest hit is the last one written.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = N-1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= N_W) cand = cand - N_W;
      if (req[cand[IDW-1:0]]) begin
        gnt_idx = cand[IDW-1:0];
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_stage_arbiter.sv
// N-way round-robin arbiter driving one registered valid/ready stage, with beat locking.
//   state      | meaning
//   ARB_IDLE   | grant follows the round-robin pointer
//   ARB_LOCKED | grant pinned to owner until it sends a beat with lock low
module rr_stage_arbiter
  import nyx_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int WIDTH = 32,
  localparam int IDW = arb_idw(N)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall_i,
  input  logic [N-1:0]       req_val_i,
  input  logic [N-1:0]       req_lock_i,
  input  logic [N*WIDTH-1:0] req_d_i,
  output logic [N-1:0]       req_rdy_o,
  input  logic               rdy_i,
  output logic               val_o,
  output logic [WIDTH-1:0]   d_o,
  output logic [IDW-1:0]     id_o
);

  arb_state_t       state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   owner;
  logic             val_r;

  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic [IDW-1:0]   g;
  logic             any;
  logic             load;
  logic             xfer;
  logic             lock_g;
  logic [WIDTH-1:0] gd;

  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] x);
    return (x == IDW'(N-1)) ? '0 : x + IDW'(1);
  endfunction

  rr_pick #(.N(N)) u_pick (
    .req     (req_val_i),
    .ptr     (ptr),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  assign val_o  = val_r & ~stall_i;
  // Held low in reset so no requester believes a beat was taken while state is cleared.
  assign load   = (rdy_i | ~val_o) & ~stall_i & reset_n;
  assign g      = (state == ARB_LOCKED) ? owner : pick_idx;
  assign any    = (state == ARB_LOCKED) ? req_val_i[owner] : pick_any;
  assign xfer   = load & any;
  assign lock_g = req_lock_i[g];

  always_comb begin
    gd        = '0;
    req_rdy_o = '0;
    for (int k = 0; k < N; k++) begin
      if (g == IDW'(k)) gd = req_d_i[k*WIDTH +: WIDTH];
      req_rdy_o[k] = xfer & (g == IDW'(k));
    end
  end

  // Output register: a load with no grant drains the stage but keeps the last payload/id.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_r <= 1'b0;
      d_o   <= '0;
      id_o  <= '0;
    end else if (load) begin
      val_r <= any;
      if (any) begin
        d_o  <= gd;
        id_o <= g;
      end
    end
  end

  // Lock FSM and round-robin pointer; while locked the pointer is frozen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      owner <= '0;
    end else if (xfer) begin
      case (state)
        ARB_IDLE: begin
          if (lock_g) begin
            state <= ARB_LOCKED;
            owner <= g;
          end else begin
            ptr <= inc_wrap(g);
          end
        end
        ARB_LOCKED: begin
          if (!lock_g) begin
            state <= ARB_IDLE;
            ptr   <= inc_wrap(owner);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_stage_arbiter.sv
// Self-checking bench: randomized and directed stimulus against a behavioural arbiter model.
module tb_rr_stage_arbiter;

  localparam int N = 4;
  localparam int WIDTH = 32;
  localparam int IDW = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               stall_i = 1'b0;
  logic               rdy_i = 1'b0;
  logic [N-1:0]       req_val_i = '0;
  logic [N-1:0]       req_lock_i = '0;
  logic [N*WIDTH-1:0] req_d_i = '0;
  logic [N-1:0]       req_rdy_o;
  logic               val_o;
  logic [WIDTH-1:0]   d_o;
  logic [IDW-1:0]     id_o;

  always #5 clk = ~clk;

  rr_stage_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall_i    (stall_i),
    .req_val_i  (req_val_i),
    .req_lock_i (req_lock_i),
    .req_d_i    (req_d_i),
    .req_rdy_o  (req_rdy_o),
    .rdy_i      (rdy_i),
    .val_o      (val_o),
    .d_o        (d_o),
    .id_o       (id_o)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Model of the stage: what sits in the output register, and whose turn it is.
  bit          m_val;
  logic [31:0] m_d;
  int          m_id;
  int          m_ptr;
  bit          m_locked;
  int          m_owner;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic m_reset();
    m_val = 0; m_d = '0; m_id = 0; m_ptr = 0; m_locked = 0; m_owner = 0;
  endtask

  function automatic int grant();
    if (m_locked) return m_owner;
    for (int off = 0; off < N; off++)
      if (req_val_i[(m_ptr + off) % N]) return (m_ptr + off) % N;
    return -1;
  endfunction

  // Compare DUT against model for the upcoming edge, then advance the model through it.
  task automatic model_cycle();
    int g;
    bit vo, ld, any;
    logic [N-1:0] er;
    if (!reset_n) begin
      chk("rst_val_o", val_o, 0);
      chk("rst_d_o", d_o, 0);
      chk("rst_id_o", id_o, 0);
      chk("rst_req_rdy_o", req_rdy_o, 0);
      m_reset();
      return;
    end
    vo  = m_val && !stall_i;
    ld  = (rdy_i || !vo) && !stall_i;
    g   = grant();
    any = (g >= 0) && req_val_i[g];
    er  = '0;
    if (ld && any) er[g] = 1'b1;
    chk("val_o", val_o, vo);
    chk("d_o", d_o, m_d);
    chk("id_o", id_o, m_id);
    chk("req_rdy_o", req_rdy_o, er);
    if (ld) begin
      m_val = any;
      if (any) begin
        m_d  = req_d_i[g*WIDTH +: WIDTH];
        m_id = g;
        if (!m_locked) begin
          if (req_lock_i[g]) begin m_locked = 1; m_owner = g; end
          else m_ptr = (g + 1) % N;
        end else if (!req_lock_i[g]) begin
          m_locked = 0;
          m_ptr = (m_owner + 1) % N;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    req_val_i  = N'($urandom);
    req_lock_i = N'($urandom & $urandom);
    stall_i    = ($urandom_range(0, 9) == 0);
    rdy_i      = ($urandom_range(0, 9) < 7);
    for (int k = 0; k < N; k++) req_d_i[k*WIDTH +: WIDTH] = $urandom;
  endtask

  logic [31:0] sv_d;

  initial begin
    m_reset();
    #1;
    // Reset held with random inputs
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      cycle();
      chk("t1_val_o", val_o, 0);
      chk("t1_d_o", d_o, 0);
      chk("t1_id_o", id_o, 0);
      chk("t1_req_rdy_o", req_rdy_o, 0);
    end
    req_val_i = '0; req_lock_i = '0; stall_i = 0; rdy_i = 1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t1_idle_val_o", val_o, 0);
      chk("t1_idle_d_o", d_o, 0);
    end

    // Round-robin fairness, all valid
    req_val_i = 4'hF;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N; k++) req_d_i[k*WIDTH +: WIDTH] = 32'h1000 * i + k;
      cycle();
      chk("t2_id_o", id_o, i % 4);
      chk("t2_d_o", d_o, 32'h1000 * i + (i % 4));
      chk("t2_val_o", val_o, 1);
    end

    // Downstream backpressure
    req_val_i = 4'b0010;
    req_d_i[1*WIDTH +: WIDTH] = 32'hA5;
    cycle();
    chk("t3_d_o", d_o, 32'hA5);
    chk("t3_val_o", val_o, 1);
    rdy_i = 0;
    req_d_i[1*WIDTH +: WIDTH] = 32'h5A;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_hold_d_o", d_o, 32'hA5);
      chk("t3_hold_val_o", val_o, 1);
      chk("t3_hold_rdy", req_rdy_o, 0);
    end
    rdy_i = 1;
    #1;
    chk("t3_resume_rdy", req_rdy_o, 4'b0010);
    cycle();
    chk("t3_next_d_o", d_o, 32'h5A);
    chk("t3_next_id_o", id_o, 1);

    // Locked burst from requester 2, then a bubble while locked
    req_val_i = 4'b1101;
    req_lock_i = 4'b0100;
    cycle(); chk("t4_b1_id", id_o, 2);
    cycle(); chk("t4_b2_id", id_o, 2);
    req_lock_i = 4'b0000;
    cycle(); chk("t4_b3_id", id_o, 2);
    cycle(); chk("t4_b4_id", id_o, 3);
    cycle(); chk("t4_b5_id", id_o, 0);
    req_lock_i = 4'b0100;
    cycle(); chk("t4_relock_id", id_o, 2);
    req_val_i = 4'b1001;
    cycle();
    chk("t4_bubble_val", val_o, 0);
    chk("t4_bubble_rdy", req_rdy_o, 0);
    req_val_i = 4'b1101;
    req_lock_i = 4'b0000;
    cycle();
    chk("t4_release_id", id_o, 2);
    chk("t4_release_val", val_o, 1);

    // Global stall mid-stream
    req_val_i = 4'hF;
    cycle(); chk("t5_pre1_id", id_o, 3);
    cycle(); chk("t5_pre2_id", id_o, 0);
    sv_d = m_d;
    stall_i = 1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("t5_stall_val", val_o, 0);
      chk("t5_stall_rdy", req_rdy_o, 0);
      chk("t5_stall_d", d_o, sv_d);
    end
    stall_i = 0;
    #1;
    chk("t5_resume_val", val_o, 1);
    cycle();
    chk("t5_resume_id", id_o, 1);

    // Async reset while locked with a beat in the output register
    req_val_i = 4'b0100;
    req_lock_i = 4'b0100;
    cycle();
    chk("t6_pre_id", id_o, 2);
    chk("t6_pre_val", val_o, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_val_o", val_o, 0);
    chk("t6_d_o", d_o, 0);
    chk("t6_id_o", id_o, 0);
    chk("t6_req_rdy_o", req_rdy_o, 0);
    m_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    req_val_i = 4'hF;
    req_lock_i = 4'b0000;
    cycle();
    chk("t6_after_id", id_o, 0);
    chk("t6_after_val", val_o, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
